inc_dec_monitor: RTL and testbench

- Receiving end of the inc/dec/c pulse interface driven by the up/down increment FSM.
- Samples inc, dec and c every clock and mirrors the producer's two-state machine (expect-inc / expect-dec).
- Counts completed inc->dec handshakes and flags protocol violations.
- Sits between the pulse generator and downstream counting/status logic; also serves as an in-system protocol checker.

---
 rtl/inc_dec_monitor_pkg.sv | 19 +
 rtl/inc_dec_monitor_sat_counter.sv | 45 ++++
 rtl/inc_dec_monitor.sv | 109 ++++++++++
 tb/tb_inc_dec_monitor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/inc_dec_monitor_pkg.sv
// Shared encodings for the inc/dec pulse-interface monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inc_dec_monitor_pkg;

    // Monitor state, mirroring the producer's two states plus a sticky error.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,    // expect c=0 and an inc pulse
        ST_ARMED = 2'd1,    // expect c=1 and a dec pulse
        ST_ERROR = 2'd2     // protocol broken; wait for clr or reset
    } state_t;

    // Cause of the most recent protocol error.
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SEQ  = 2'b01;    // pulse out of order
    localparam logic [1:0] ERR_BOTH = 2'b10;    // inc and dec together
    localparam logic [1:0] ERR_SYNC = 2'b11;    // c level disagrees with mirrored state

endpackage : inc_dec_monitor_pkg

// File: rtl/inc_dec_monitor_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; sat flag registered.
// Latency: count and sat reflect en/clr one cycle after the sampling edge.
// Backpressure: none; once at CNT_MAX further enables are absorbed (no wrap).
module inc_dec_monitor_sat_counter #(
    parameter int          CNT_W   = 8,
    parameter int unsigned CNT_MAX = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q;

    // Next count: clear wins, otherwise step up unless already at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count and saturation flag registered together so sat matches count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= (cnt_d == MAX_V);
        end
    end

    assign count_o = cnt_q;
    assign sat_o   = sat_q;

endmodule : inc_dec_monitor_sat_counter

// File: rtl/inc_dec_monitor.sv
// Receive-side monitor of the inc/dec/c pulse interface: counts handshakes, flags violations.
// Latency: all outputs registered, 1 cycle after the sampled edge.
// Backpressure: none; the producer is never stalled, violations latch err until clr/reset.
module inc_dec_monitor
    import inc_dec_monitor_pkg::*;
#(
    parameter int          CNT_W   = 8,
    parameter int unsigned CNT_MAX = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             reset,      // async, active low
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    input  logic             c,
    output logic [CNT_W-1:0] count,
    output logic             armed,
    output logic             sat,
    output logic             err,
    output logic [1:0]       err_code
);

    state_t     state_q, state_d;
    logic [1:0] err_code_q, err_code_d;
    logic       cnt_en;
    logic       cnt_clr;

    // Next state, error cause and counter controls, in evaluation priority order.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;

        if (clr) begin
            state_d    = ST_IDLE;
            err_code_d = ERR_NONE;
            cnt_clr    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (inc && dec) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_BOTH;
                    end else if (c) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_SYNC;
                    end else if (inc) begin
                        state_d = ST_ARMED;
                    end else if (dec) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_SEQ;
                    end
                end
                ST_ARMED: begin
                    if (inc && dec) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_BOTH;
                    end else if (!c) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_SYNC;
                    end else if (dec) begin
                        state_d = ST_IDLE;
                        cnt_en  = 1'b1;
                    end else if (inc) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_SEQ;
                    end
                end
                ST_ERROR: begin
                    // Sticky: inputs ignored, only clr or reset leaves.
                    state_d = ST_ERROR;
                end
                default: begin
                    // Unused encoding: treat as a broken monitor.
                    state_d = ST_ERROR;
                end
            endcase
        end
    end

    // State and error-cause registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
        end
    end

    inc_dec_monitor_sat_counter #(
        .CNT_W   (CNT_W),
        .CNT_MAX (CNT_MAX)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (count),
        .sat_o   (sat)
    );

    assign armed    = (state_q == ST_ARMED);
    assign err      = (state_q == ST_ERROR);
    assign err_code = err_code_q;

endmodule : inc_dec_monitor

// File: tb/tb_inc_dec_monitor.sv
// Directed bench for inc_dec_monitor: a default-width instance and a 2-bit instance share stimulus.
// Latency: outputs checked #1 after the edge that sampled each step.
// Backpressure: n/a.
module tb_inc_dec_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr, inc, dec, c;

    logic [7:0] count;
    logic       armed, sat, err;
    logic [1:0] err_code;

    logic [1:0] count2;
    logic       armed2, sat2, err2;
    logic [1:0] err_code2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inc_dec_monitor u_dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .inc      (inc),
        .dec      (dec),
        .c        (c),
        .count    (count),
        .armed    (armed),
        .sat      (sat),
        .err      (err),
        .err_code (err_code)
    );

    inc_dec_monitor #(.CNT_W(2)) u_dut2 (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .inc      (inc),
        .dec      (dec),
        .c        (c),
        .count    (count2),
        .armed    (armed2),
        .sat      (sat2),
        .err      (err2),
        .err_code (err_code2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then land just after the sampling edge.
    task automatic step(input logic i_inc, input logic i_dec, input logic i_c, input logic i_clr);
        @(negedge clk);
        inc = i_inc;
        dec = i_dec;
        c   = i_c;
        clr = i_clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input int exp_cnt, input logic exp_armed,
                              input logic exp_err, input logic [1:0] exp_code);
        check({tag, ".count"},    32'(count),    32'(exp_cnt));
        check({tag, ".armed"},    32'(armed),    32'(exp_armed));
        check({tag, ".err"},      32'(err),      32'(exp_err));
        check({tag, ".err_code"}, 32'(err_code), 32'(exp_code));
    endtask

    initial begin
        reset = 1'b0;
        clr   = 1'b0;
        inc   = 1'b0;
        dec   = 1'b0;
        c     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_main("reset", 0, 1'b0, 1'b0, 2'b00);
        check("reset.sat",    32'(sat),    32'd0);
        check("reset.count2", 32'(count2), 32'd0);
        check("reset.sat2",   32'(sat2),   32'd0);

        @(negedge clk);
        reset = 1'b1;

        // Five clean handshakes: 8-bit counts 1..5, 2-bit counter stops at 3.
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check("hs.inc.armed", 32'(armed), 32'd1);
            check("hs.inc.count", 32'(count), 32'(k - 1));
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("hs.hold.armed", 32'(armed), 32'd1);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            check_main("hs.dec", k, 1'b0, 1'b0, 2'b00);
            check("hs.sat",    32'(sat),    32'd0);
            check("hs.count2", 32'(count2), 32'((k < 3) ? k : 3));
            check("hs.sat2",   32'(sat2),   32'((k >= 3) ? 1 : 0));
            check("hs.err2",   32'(err2),   32'd0);
        end

        // Arm with count=5, then pull reset mid-cycle: outputs must clear before the next edge.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("prearst.armed", 32'(armed), 32'd1);
        check("prearst.count", 32'(count), 32'd5);
        @(negedge clk);
        c = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_main("arst", 0, 1'b0, 1'b0, 2'b00);
        check("arst.sat2", 32'(sat2), 32'd0);
        @(negedge clk);
        inc   = 1'b0;
        dec   = 1'b0;
        c     = 1'b0;
        reset = 1'b1;

        // One handshake, then inc&dec together in IDLE.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_main("pre_both", 1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_main("both", 1, 1'b0, 1'b1, 2'b10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_main("err.ign_inc", 1, 1'b0, 1'b1, 2'b10);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_main("err.ign_dec", 1, 1'b0, 1'b1, 2'b10);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_main("clr", 0, 1'b0, 1'b0, 2'b00);

        // dec while IDLE.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_main("seq.dec_idle", 0, 1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // inc again while ARMED.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("seq.arm", 32'(armed), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_main("seq.inc_armed", 0, 1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // c=1 while IDLE with no pulse.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_main("sync.idle", 0, 1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // c=0 while ARMED with no pulse.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_main("sync.armed", 0, 1'b0, 1'b1, 2'b11);

        // clr wins over a valid dec while armed: no count, back to IDLE.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_main("clr_prio", 0, 1'b0, 1'b0, 2'b00);

        // inc&dec while ARMED outranks the c check and sequence check.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_main("both.armed", 0, 1'b0, 1'b1, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_inc_dec_monitor
